// File: rtl/tester_test_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tester_test_ctrl
//  Purpose  : Sequences one timed speed test across all tester ports.
//  Revision : 1.0 - initial release
// ============================================================================
module tester_test_ctrl #(
    parameter int CLK_FREQ_HZ  = 125000000,
    parameter int NUM_PORTS    = 4,
    parameter int DRAIN_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_start,
    input  logic                 cfg_stop,
    input  logic [12:0]          cfg_duration,
    input  logic [NUM_PORTS-1:0] port_enable,
    output logic                 busy,
    output logic [NUM_PORTS-1:0] gen_run,
    output logic                 stats_clear,
    output logic                 stats_freeze,
    output logic [12:0]          actual_duration,
    output logic                 done
);

    localparam int TICKS_PER_MS = CLK_FREQ_HZ / 1000;
    localparam int PW           = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
    localparam int DW           = $clog2(DRAIN_CYCLES + 1);

    localparam logic [PW-1:0] c_presc_max = PW'(TICKS_PER_MS - 1);
    localparam logic [DW-1:0] c_drain_max = DW'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [NUM_PORTS-1:0]   r_en_snap;
    logic [12:0]            r_dur;
    logic [PW-1:0]          r_presc;
    logic [12:0]            r_ms_count;
    logic [DW-1:0]          r_drain_cnt;
    logic [12:0]            r_meas;
    logic [12:0]            w_meas_next;
    logic [12:0]            w_ms_inc;
    logic                   w_wrap;
    logic                   w_accept;

    always_comb begin
        w_state_next = r_state;
        w_meas_next  = r_meas;
        w_ms_inc     = r_ms_count + 13'd1;
        w_wrap       = (r_state == S_RUN) && (r_presc == c_presc_max);
        w_accept     = (cfg_duration != 13'd0) && (port_enable != '0);

        case (r_state)
            S_IDLE: begin
                if (cfg_start) begin
                    if (w_accept) begin
                        w_state_next = S_CLEAR;
                    end else begin
                        w_state_next = S_DONE;
                        w_meas_next  = 13'd0;
                    end
                end
            end
            S_CLEAR: w_state_next = S_RUN;
            S_RUN: begin
                // The terminal wrap takes priority so a coincident stop still reports the full duration.
                if (w_wrap && (w_ms_inc == r_dur)) begin
                    w_state_next = S_DRAIN;
                    w_meas_next  = r_dur;
                end else if (cfg_stop) begin
                    w_state_next = S_DRAIN;
                    w_meas_next  = r_ms_count;
                end
            end
            S_DRAIN: begin
                if (r_drain_cnt == c_drain_max) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_en_snap       <= '0;
            r_dur           <= 13'd0;
            r_presc         <= '0;
            r_ms_count      <= 13'd0;
            r_drain_cnt     <= '0;
            r_meas          <= 13'd0;
            busy            <= 1'b0;
            gen_run         <= '0;
            stats_clear     <= 1'b0;
            stats_freeze    <= 1'b1;
            actual_duration <= 13'd0;
            done            <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_meas  <= w_meas_next;

            if ((r_state == S_IDLE) && cfg_start && w_accept) begin
                r_en_snap <= port_enable;
                r_dur     <= cfg_duration;
            end

            if (r_state == S_CLEAR) begin
                r_presc    <= '0;
                r_ms_count <= 13'd0;
            end else if (r_state == S_RUN) begin
                if (w_wrap) begin
                    r_presc    <= '0;
                    r_ms_count <= w_ms_inc;
                end else begin
                    r_presc <= r_presc + 1'b1;
                end
            end

            if (r_state == S_DRAIN) begin
                r_drain_cnt <= r_drain_cnt + 1'b1;
            end else begin
                r_drain_cnt <= '0;
            end

            // Outputs are registered from the next state so they line up with the state they describe.
            busy         <= (w_state_next == S_CLEAR) || (w_state_next == S_RUN) ||
                            (w_state_next == S_DRAIN);
            stats_freeze <= (w_state_next == S_IDLE) || (w_state_next == S_DONE);
            stats_clear  <= (w_state_next == S_CLEAR);
            gen_run      <= (w_state_next == S_RUN) ? r_en_snap : '0;
            done         <= (w_state_next == S_DONE);
            if (w_state_next == S_DONE) begin
                actual_duration <= w_meas_next;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tester_test_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tester_test_ctrl
//  Purpose  : Self-checking bench for tester_test_ctrl (done events scoreboarded).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tester_test_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_start;
    logic        cfg_stop;
    logic [12:0] cfg_duration;
    logic [3:0]  port_enable;
    logic        busy;
    logic [3:0]  gen_run;
    logic        stats_clear;
    logic        stats_freeze;
    logic [12:0] actual_duration;
    logic        done;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int          at;
        logic [12:0] dur;
    } exp_t;

    exp_t q[$];
    exp_t m_e;

    tester_test_ctrl #(
        .CLK_FREQ_HZ (10000),
        .NUM_PORTS   (4),
        .DRAIN_CYCLES(5)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_start      (cfg_start),
        .cfg_stop       (cfg_stop),
        .cfg_duration   (cfg_duration),
        .port_enable    (port_enable),
        .busy           (busy),
        .gen_run        (gen_run),
        .stats_clear    (stats_clear),
        .stats_freeze   (stats_freeze),
        .actual_duration(actual_duration),
        .done           (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done at cycle %0d: got done=1 expected none", cyc);
            end else begin
                m_e = q.pop_front();
                chk("done_cycle", cyc, m_e.at);
                chk("done_actual_duration", {19'd0, actual_duration}, {19'd0, m_e.dur});
            end
        end
    end

    task automatic chk_outs(input logic b, input logic [3:0] g, input logic c);
        chk("busy", {31'd0, busy}, {31'd0, b});
        chk("gen_run", {28'd0, gen_run}, {28'd0, g});
        chk("stats_clear", {31'd0, stats_clear}, {31'd0, c});
        chk("stats_freeze", {31'd0, stats_freeze}, {31'd0, ~b});
    endtask

    // One accepted test; stop_k = cycle offset of cfg_stop (0 = none).
    task automatic run_test(input logic [12:0] dur, input logic [3:0] en, input int stop_k,
                            input bit ignore, input bit stop_with_start);
        int          nat_last;
        int          last;
        logic [12:0] meas;
        logic [3:0]  g;
        nat_last = 1 + int'(dur) * 10;
        if (stop_k >= 2 && stop_k <= nat_last) begin
            last = stop_k;
            meas = (stop_k == nat_last) ? dur : 13'((stop_k - 2) / 10);
        end else begin
            last = nat_last;
            meas = dur;
        end
        @(negedge clk);
        cfg_start    = 1'b1;
        cfg_stop     = stop_with_start;
        cfg_duration = dur;
        port_enable  = en;
        q.push_back('{cyc + last + 6, meas});
        for (int k = 1; k <= last + 6; k++) begin
            @(negedge clk);
            g = (k >= 2 && k <= last) ? en : 4'b0000;
            chk_outs(k <= last + 5, g, k == 1);
            cfg_start   = ignore && (k == 15);
            cfg_stop    = (k == stop_k) || (ignore && (k == last + 2));
            port_enable = (ignore && k >= 10) ? ~en : en;
        end
        cfg_stop    = 1'b0;
        port_enable = en;
    endtask

    task automatic reject(input logic [12:0] dur, input logic [3:0] en);
        @(negedge clk);
        cfg_start    = 1'b1;
        cfg_duration = dur;
        port_enable  = en;
        q.push_back('{cyc + 1, 13'd0});
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            cfg_start = 1'b0;
            chk_outs(1'b0, 4'b0000, 1'b0);
        end
    endtask

    initial begin
        rst          = 1'b1;
        cfg_start    = 1'b0;
        cfg_stop     = 1'b0;
        cfg_duration = 13'd0;
        port_enable  = 4'b0000;
        repeat (3) @(negedge clk);
        chk_outs(1'b0, 4'b0000, 1'b0);
        chk("reset_actual_duration", {19'd0, actual_duration}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        rst = 1'b0;

        run_test(13'd3, 4'b0101, 0, 1'b0, 1'b0);      // nominal
        run_test(13'd3, 4'b0101, 0, 1'b1, 1'b0);      // ignored commands
        run_test(13'd100, 4'b1111, 26, 1'b0, 1'b0);   // abort -> 2 ms
        reject(13'd0, 4'b1111);
        run_test(13'd2, 4'b0011, 21, 1'b0, 1'b0);     // stop on final wrap
        reject(13'd5, 4'b0000);
        run_test(13'd1, 4'b1010, 0, 1'b0, 1'b1);      // start+stop in IDLE

        // Reset in the middle of RUN
        @(negedge clk);
        cfg_start    = 1'b1;
        cfg_duration = 13'd3;
        port_enable  = 4'b1111;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            cfg_start = 1'b0;
            if (k == 10) rst = 1'b1;
        end
        chk_outs(1'b0, 4'b0000, 1'b0);
        chk("rst_actual_duration", {19'd0, actual_duration}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            chk("rst_no_busy", {31'd0, busy}, 32'd0);
        end
        run_test(13'd3, 4'b0101, 0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tester_test_ctrl.md
# tester_test_ctrl

Sequences one speed test across all tester ports. Takes the start command and the millisecond duration from the test config register and derives a millisecond tick from the core clock. It gates the per-port frame generators, clears and freezes the per-port statistics, and waits a drain window after the generators stop. It then reports the actual test duration back to the config register. It sits between the register file (`test_config_t` / `port_config_t.enable`) and the per-port generator/checker pairs.

## Interface
Parameters:
- CLK_FREQ_HZ, 125000000, core clock frequency; TICKS_PER_MS = CLK_FREQ_HZ/1000 (must divide exactly, ≥2)
- NUM_PORTS, 4, number of tester ports
- DRAIN_CYCLES, 1024, cycles to wait after generators stop so that in-flight frames reach the checkers (≥1)

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- cfg_start  in  1  one-cycle pulse when software writes `start`=1
- cfg_stop  in  1  one-cycle abort pulse
- cfg_duration  in  13  requested duration in ms (`test_duration_t`)
- port_enable  in  NUM_PORTS  `enable` bit of each `port_config_t`
- busy  out  1  test in progress; drives the `busy` register bit
- gen_run  out  NUM_PORTS  per-port generator run gate
- stats_clear  out  1  one-cycle clear of all `port_result_t` counters
- stats_freeze  out  1  checkers must not update counters while high
- actual_duration  out  13  measured duration in ms
- done  out  1  one-cycle pulse; actual_duration is valid and is written back to `duration`

## Operation
- FSM states: IDLE, CLEAR, RUN, DRAIN, DONE.
- IDLE:
  - cfg_start with cfg_duration≠0 and port_enable≠0 → latch en_snap=port_enable and dur=cfg_duration, then go to CLEAR.
  - cfg_start with cfg_duration=0 or port_enable=0 → go to DONE with actual_duration=0. No clear and no run.
  - cfg_stop is ignored. If start and stop arrive together, start wins.
- CLEAR: lasts 1 cycle with stats_clear=1. Prescaler and ms_count are zeroed. Then go to RUN.
- RUN:
  - gen_run=en_snap.
  - The prescaler counts 0..TICKS_PER_MS-1 and wraps. On wrap, ms_count increments (13 bits).
  - When a wrap makes ms_count==dur, go to DRAIN with actual_duration=dur.
  - cfg_stop → go to DRAIN with actual_duration=ms_count (completed ms only; a partial ms is discarded).
  - If stop coincides with the final wrap, actual_duration=dur.
  - ms_count cannot overflow because the terminal check happens at equality and dur≤8191.
- DRAIN: gen_run=0. Count DRAIN_CYCLES cycles, then go to DONE. cfg_start and cfg_stop are ignored.
- DONE: lasts 1 cycle with done=1, then returns to IDLE.
- cfg_start while busy is ignored; it does not restart the test.
- port_enable changes after start have no effect; only en_snap is used.
- busy=1 in CLEAR, RUN and DRAIN; busy=0 in IDLE and DONE.
- stats_freeze=0 in CLEAR, RUN and DRAIN; stats_freeze=1 in IDLE and DONE.
- actual_duration holds its value until the next DONE.

## Timing
- All outputs are registered.
- Reset values: state=IDLE, busy=0, gen_run=0, stats_clear=0, stats_freeze=1, actual_duration=0, done=0.
- Reset mid-test: the cycle after rst, gen_run=0 and all outputs are at reset values. No done pulse is issued.
- Nominal timeline for cfg_start at cycle T:
  - T+1: stats_clear=1, busy=1.
  - T+2: gen_run rises.
  - gen_run stays high for exactly dur·TICKS_PER_MS cycles.
  - gen_run falls on the same cycle DRAIN is entered.
  - DRAIN occupies DRAIN_CYCLES cycles.
  - The next cycle has done=1 with busy=0.
- Stop latency: cfg_stop at cycle S in RUN → gen_run=0 at S+1.
- Rejected start at cycle T → done=1 at T+1 and actual_duration=0 at T+1.
- A cfg_start accepted on the cycle immediately after done (state IDLE) is a valid new test.

## Test plan
Params for all scenarios: CLK_FREQ_HZ=10000 (TICKS_PER_MS=10), DRAIN_CYCLES=5, NUM_PORTS=4.
- Nominal run:
  - Stimulus: duration=3, port_enable=4'b0101, start at T.
  - Required: stats_clear at T+1; gen_run=4'b0101 for cycles T+2..T+31; DRAIN T+32..T+36; done at T+37 with actual_duration=3; busy high T+1..T+36.
- Abort:
  - Stimulus: duration=100, start at T, stop at T+26.
  - Required: gen_run=0 at T+27; actual_duration=2; done at T+32.
- Rejected start:
  - Stimulus: duration=0 (then, separately, port_enable=0).
  - Required: done at T+1, actual_duration=0, busy never high, gen_run never high, stats_clear never pulsed.
- Ignored commands:
  - Stimulus: start again mid-RUN, stop during DRAIN, port_enable changed mid-RUN.
  - Required: timeline and gen_run identical to the nominal run.
- Coincident events:
  - Stimulus: stop on the cycle of the final ms wrap (duration=2); start and stop together in IDLE.
  - Required: actual_duration=2 and the test starts normally, respectively.
- Reset mid-RUN:
  - Stimulus: rst for one cycle at T+10.
  - Required: all outputs at reset values at T+11, no done; a new start afterwards runs the nominal timeline.
